out_port_tx: RTL

// - Peripheral on the far side of the CPU output port. Each OUT instruction

---
 rtl/out_port_tx_if.sv | 21 ++
 rtl/out_port_tx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/out_port_tx_if.sv
// Write-side and status signals between the CPU output port and the serial transmitter.
interface out_port_tx_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic       tx;
  logic       busy;
  logic       full;
  logic       empty;
  logic       overflow;

  modport master (
    output wr_en, wr_data, clr_ovf,
    input  tx, busy, full, empty, overflow
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf,
    output tx, busy, full, empty, overflow
  );
endinterface

// File: rtl/out_port_tx.sv
// Output-port peripheral: buffers OUT bytes in a small FIFO and sends each one as an 8N1 frame.
module out_port_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_AW      = 2
) (
  input logic          clk,
  input logic          rst_n,
  out_port_tx_if.slave bus_io
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam int unsigned TmrW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TmrW-1:0]  TmrLast   = TmrW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] CountFull = (FIFO_AW + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // FIFO storage and bookkeeping
  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               full, empty, push, pop, drop;
  logic [7:0]         head;

  // Serialiser
  state_e          state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            bit_end;

  assign full  = (count_q == CountFull);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a write to a full FIFO is still accepted.
  assign push = bus_io.wr_en && (!full || pop);
  assign drop = bus_io.wr_en && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus_io.clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus_io.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bit_end = (tmr_q == TmrLast);

  // tx_d carries the line level of the state being entered so that tx stays registered.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = head;
          tmr_d   = '0;
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          tmr_d   = '0;
          idx_d   = '0;
          state_d = StData;
          tx_d    = shreg_q[0];
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          tmr_d   = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            tx_d  = shreg_q[1];
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          tmr_d = '0;
          if (!empty) begin
            // Chain straight into the next start bit with no idle gap.
            pop     = 1'b1;
            shreg_d = head;
            state_d = StStart;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  assign bus_io.tx       = tx_q;
  assign bus_io.busy     = (state_q != StIdle);
  assign bus_io.full     = full;
  assign bus_io.empty    = empty;
  assign bus_io.overflow = ovf_q;

endmodule
